// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one Memory between the fetch port and the load/store port.
// Define ARBITER_ROUND_ROBIN_EN for round-robin; otherwise data port has fixed priority.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_response,
  output logic [DATA_WIDTH-1:0] i_read_data,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [2:0]            d_option,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_write_data,
  output logic                  d_response,
  output logic [DATA_WIDTH-1:0] d_read_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [2:0]            mem_option,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_response,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  cmd_read_q, cmd_read_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [2:0]            cmd_option_q, cmd_option_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic i_req;
  logic d_req;
  logic win_d;
  logic access;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef ARBITER_ROUND_ROBIN_EN
  assign win_d = d_req & (~i_req | (last_grant_q == GNT_I));
`else
  logic unused_last_grant;
  assign win_d = d_req;
  assign unused_last_grant = last_grant_q;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cmd_read_d   = cmd_read_q;
    cmd_write_d  = cmd_write_q;
    cmd_option_d = cmd_option_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          state_d = ACCESS;
          if (win_d) begin
            grant_d      = GNT_D;
            cmd_read_d   = d_read & ~d_write;
            cmd_write_d  = d_write;
            cmd_option_d = d_option;
            cmd_addr_d   = d_address;
            cmd_wdata_d  = d_write_data;
          end else begin
            grant_d      = GNT_I;
            cmd_read_d   = 1'b1;
            cmd_write_d  = 1'b0;
            cmd_option_d = 3'b010;
            cmd_addr_d   = i_address;
            cmd_wdata_d  = '0;
          end
        end
      end
      ACCESS: begin
        if (mem_response) begin
          state_d = DONE;
          if (grant_q == GNT_D) d_rdata_d = mem_read_data;
          else                  i_rdata_d = mem_read_data;
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= GNT_I;
      last_grant_q <= GNT_I;
      cmd_read_q   <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_option_q <= '0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cmd_read_q   <= cmd_read_d;
      cmd_write_q  <= cmd_write_d;
      cmd_option_q <= cmd_option_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Reset kills the command immediately so an aborted store never reaches Memory.
  assign access = (state_q == ACCESS) & ~reset;

  assign mem_read       = access & (cmd_read_q | cmd_write_q);
  assign mem_write      = access & cmd_write_q;
  assign mem_option     = access ? cmd_option_q : '0;
  assign mem_address    = access ? cmd_addr_q : '0;
  assign mem_write_data = access ? cmd_wdata_q : '0;

  assign i_response  = (state_q == DONE) & (grant_q == GNT_I);
  assign d_response  = (state_q == DONE) & (grant_q == GNT_D);
  assign i_read_data = i_rdata_q;
  assign d_read_data = d_rdata_q;
endmodule
